attention_stream_driver: RTL
============================

Name: attention_stream_driver

Overview:
- Initiator-side counterpart of the attention score engine.
- Holds one query vector and NUM_KEYS key vectors, then serializes interleaved Q/K bytes onto the engine's valid/ready input stream.
- Collects one 9-bit UQ3.6 exp score per key from the engine's output stream, stores the scores and accumulates the softmax denominator.
- Sits in the host/test-harness layer, facing the engine's ui_in/uio pins.

Parameters:
- FEATURES, 4, elements per vector; must match the engine MAC depth.
- NUM_KEYS, 4, key vectors scored per run.
- DATA_W, 8, Q0.7 element width.
- EXP_W, 9, UQ3.6 score width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- start_i  in  1  begin a run; latches q_vec_i; ignored when busy_o=1
- q_vec_i  in  FEATURES*DATA_W  query vector, element f at bits [f*DATA_W +: DATA_W]
- k_wr_en_i  in  1  key memory write strobe
- k_wr_addr_i  in  clog2(NUM_KEYS*FEATURES)  address = key*FEATURES + feature
- k_wr_data_i  in  DATA_W  key element, Q0.7
- m_data_o  out  DATA_W  byte to engine (ui_in)
- m_vld_o  out  1  byte valid (engine uio_in[0])
- m_rdy_i  in  1  engine ready (uio_out[1])
- s_data_i  in  EXP_W  engine score ({uio_out[4], uo_out})
- s_vld_i  in  1  engine score valid (uio_out[2])
- s_rdy_o  out  1  score accept (engine uio_in[3])
- res_addr_i  in  clog2(NUM_KEYS)  score read index
- res_data_o  out  EXP_W  combinational read of score[res_addr_i]
- sum_o  out  EXP_W+clog2(NUM_KEYS)  sum of all scores of the last run
- argmax_o  out  clog2(NUM_KEYS)  index of the largest score (optional feature)
- busy_o  out  1  run in progress
- done_o  out  1  one-cycle pulse at end of run

Behaviour:
- Reset values: all outputs 0, FSM IDLE, sum, counters and scores cleared. Key memory is not cleared.
- FSM states and transitions:
  - IDLE: start_i latches q_vec_i, clears sum and key index j -> SEND.
  - SEND: emits 2*FEATURES beats for key j, in the order q[0], k[j][0], q[1], k[j][1], …, k[j][FEATURES-1].
    - m_vld_o=1 for the whole state.
    - A beat advances only when m_vld_o && m_rdy_i.
    - m_data_o is held stable while m_rdy_i=0.
    - After the last beat is accepted -> WAIT_RES in the next cycle.
  - WAIT_RES: m_vld_o=0, s_rdy_o=1.
    - On s_vld_i: score[j] <= s_data_i; sum += s_data_i (unsigned, no overflow by width); j++.
    - If j was NUM_KEYS-1 -> DONE, else -> SEND.
  - DONE: done_o=1 for exactly one cycle -> IDLE.
- busy_o=1 in SEND, WAIT_RES and DONE.
- s_rdy_o=0 outside WAIT_RES; s_vld_i outside WAIT_RES is ignored.
- k_wr_en_i while busy_o=1 is ignored, so key memory stays stable during a run.
- start_i while busy_o=1 is ignored.
- start_i in the same cycle as done_o is ignored; the next start is accepted from the IDLE cycle.
- Latency: first beat is valid in the cycle after start_i. With m_rdy_i=1 and the score returned the cycle after the last beat, each key takes 2*FEATURES+1 cycles.
- Asserting rst_n low mid-run aborts immediately: m_vld_o and s_rdy_o go to 0 asynchronously. Scores and sum are cleared.
- res_data_o and sum_o stay valid after done_o until the next start_i.

Optional Feature:
- Macro: ATTN_DRV_ARGMAX_EN.
- Defined: a running max register and index are updated on each score capture using strict greater-than, so the first maximum wins on ties. argmax_o is valid from done_o onward. Max and index clear at start_i.
- Undefined: argmax_o is tied to 0 and no comparator is built.

Decomposition:
- Package attention_pkg:
  - drv_state_t enum (IDLE, SEND, WAIT_RES, DONE).
  - Widths DATA_W=8, EXP_W=9.
  - Score fixed-point constant UQ3.6 ONE = 9'h040.
- One sub-module, attention_kmem: key register file with a synchronous write port and an asynchronous read port, addressed by {j, beat>>1}.

Test Plan:
- Ordering: q=[01,02,03,04], k0=[11,12,13,14], m_rdy_i=1 -> m_data_o sequence 01,11,02,12,03,13,04,14, then m_vld_o=0 and s_rdy_o=1.
- Scores: scripted responder returns 040, 080, 020, 100 for keys 0–3 -> res_data_o[0..3] match, sum_o=0x1E0, done_o pulses once, argmax_o=3 (feature on) or 0 (feature off).
- Backpressure: m_rdy_i pattern 1,0,0,1,0,1… -> no beat lost or duplicated, and m_data_o is unchanged during every m_rdy_i=0 cycle.
- Protocol guards: s_vld_i=1 during SEND is not captured; start_i and k_wr_en_i during a run have no effect (same results as a clean run).
- Reset mid-run: deassert rst_n during beat 5 of key 2 -> m_vld_o=0 immediately, busy_o=0, sum_o=0. A fresh start then reproduces the full 4-key sequence.
- Ties: scores 0C0, 0C0, 040, 0C0 -> argmax_o=0, sum_o=0x280.

Source files
------------

// File: rtl/attention_pkg.sv
// Shared types and constants for the attention stream driver.
//   drv_state_t : driver FSM states
//   DATA_W      : Q0.7 vector element width
//   EXP_W       : UQ3.6 exp score width
//   EXP_ONE     : 1.0 in UQ3.6
package attention_pkg;

  localparam int DATA_W = 8;
  localparam int EXP_W  = 9;

  localparam logic [EXP_W-1:0] EXP_ONE = 9'h040;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } drv_state_t;

endpackage

// File: rtl/attention_kmem.sv
// Key register file for the attention stream driver.
// Synchronous write port, asynchronous (combinational) read port.
// Contents have no reset: keys survive a driver reset.
//   clk        : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address (key*FEATURES + feature)
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data, combinational
module attention_kmem import attention_pkg::*; #(
  parameter  int DEPTH = 16,
  parameter  int W     = DATA_W,
  localparam int A_W   = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           wr_en_i,
  input  logic [A_W-1:0] wr_addr_i,
  input  logic [W-1:0]   wr_data_i,
  input  logic [A_W-1:0] rd_addr_i,
  output logic [W-1:0]   rd_data_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/attention_stream_driver.sv
// Initiator-side driver for the attention score engine.
// Latches a query vector on start, then per key streams interleaved
// q[0],k[j][0],q[1],k[j][1],... bytes over a valid/ready stream, waits for
// one UQ3.6 exp score, stores it and accumulates the softmax denominator.
//
// Optional feature (macro ATTN_DRV_ARGMAX_EN): running max + index of the
// largest score, first maximum wins on ties. Undefined: argmax_o tied to 0.
//
// FEATURES and NUM_KEYS are expected to be >= 2.
//
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   start_i        : begin a run (IDLE only), latches q_vec_i
//   q_vec_i        : query vector, element f at [f*DATA_W +: DATA_W]
//   k_wr_*         : key memory write port (ignored while busy_o)
//   m_data_o/m_vld_o/m_rdy_i : byte stream to the engine
//   s_data_i/s_vld_i/s_rdy_o : score stream from the engine
//   res_addr_i/res_data_o    : combinational score read
//   sum_o          : sum of the last run's scores
//   argmax_o       : index of the largest score
//   busy_o         : run in progress (SEND, WAIT_RES, DONE)
//   done_o         : one-cycle end-of-run pulse
module attention_stream_driver #(
  parameter  int FEATURES = 4,
  parameter  int NUM_KEYS = 4,
  parameter  int DATA_W   = attention_pkg::DATA_W,
  parameter  int EXP_W    = attention_pkg::EXP_W,
  localparam int KA_W     = $clog2(NUM_KEYS*FEATURES),
  localparam int J_W      = $clog2(NUM_KEYS),
  localparam int SUM_W    = EXP_W + $clog2(NUM_KEYS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_i,
  input  logic [FEATURES*DATA_W-1:0] q_vec_i,
  input  logic                       k_wr_en_i,
  input  logic [KA_W-1:0]            k_wr_addr_i,
  input  logic [DATA_W-1:0]          k_wr_data_i,
  output logic [DATA_W-1:0]          m_data_o,
  output logic                       m_vld_o,
  input  logic                       m_rdy_i,
  input  logic [EXP_W-1:0]           s_data_i,
  input  logic                       s_vld_i,
  output logic                       s_rdy_o,
  input  logic [J_W-1:0]             res_addr_i,
  output logic [EXP_W-1:0]           res_data_o,
  output logic [SUM_W-1:0]           sum_o,
  output logic [J_W-1:0]             argmax_o,
  output logic                       busy_o,
  output logic                       done_o
);

  import attention_pkg::*;

  // beat[0] selects query (0) / key (1); beat[B_W-1:1] is the element index
  localparam int F_W  = $clog2(FEATURES);
  localparam int B_W  = F_W + 1;
  localparam logic [B_W-1:0] LAST_BEAT = B_W'(2*FEATURES - 1);
  localparam logic [J_W-1:0] LAST_KEY  = J_W'(NUM_KEYS - 1);

  drv_state_t                           state_q;
  logic [J_W-1:0]                       j_q;
  logic [B_W-1:0]                       beat_q;
  logic [FEATURES-1:0][DATA_W-1:0]      qv_q;
  logic [NUM_KEYS-1:0][EXP_W-1:0]       score_q;
  logic [SUM_W-1:0]                     sum_q;

  logic [F_W-1:0]    elem;
  logic [KA_W-1:0]   k_rd_addr;
  logic [DATA_W-1:0] k_rd_data;
  logic              start_ok;
  logic              capture;

  assign elem      = beat_q[B_W-1:1];
  assign k_rd_addr = KA_W'(j_q) * KA_W'(FEATURES) + KA_W'(elem);
  assign start_ok  = (state_q == IDLE) && start_i;
  assign capture   = (state_q == WAIT_RES) && s_vld_i;

  // Writes are blocked outside IDLE so the key under transfer cannot change.
  attention_kmem #(
    .DEPTH (NUM_KEYS*FEATURES),
    .W     (DATA_W)
  ) u_kmem (
    .clk       (clk),
    .wr_en_i   (k_wr_en_i && (state_q == IDLE)),
    .wr_addr_i (k_wr_addr_i),
    .wr_data_i (k_wr_data_i),
    .rd_addr_i (k_rd_addr),
    .rd_data_o (k_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      j_q     <= '0;
      beat_q  <= '0;
      qv_q    <= '0;
      score_q <= '0;
      sum_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            qv_q    <= q_vec_i;
            sum_q   <= '0;
            j_q     <= '0;
            beat_q  <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          // beat_q only moves on a handshake, which keeps m_data_o stable
          if (m_rdy_i) begin
            if (beat_q == LAST_BEAT) begin
              beat_q  <= '0;
              state_q <= WAIT_RES;
            end else begin
              beat_q <= beat_q + 1'b1;
            end
          end
        end
        WAIT_RES: begin
          if (s_vld_i) begin
            score_q[j_q] <= s_data_i;
            sum_q        <= sum_q + SUM_W'(s_data_i);
            j_q          <= j_q + 1'b1;
            state_q      <= (j_q == LAST_KEY) ? DONE : SEND;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stream controls decode straight from the state register, so an async
  // reset drops them immediately.
  assign m_vld_o    = (state_q == SEND);
  assign s_rdy_o    = (state_q == WAIT_RES);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign m_data_o   = m_vld_o ? (beat_q[0] ? k_rd_data : qv_q[elem]) : '0;
  assign res_data_o = score_q[res_addr_i];
  assign sum_o      = sum_q;

`ifdef ATTN_DRV_ARGMAX_EN
  logic [EXP_W-1:0] max_q;
  logic [J_W-1:0]   arg_q;

  // Strict greater-than: an equal later score never displaces the first max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      arg_q <= '0;
    end else if (start_ok) begin
      max_q <= '0;
      arg_q <= '0;
    end else if (capture && (s_data_i > max_q)) begin
      max_q <= s_data_i;
      arg_q <= j_q;
    end
  end

  assign argmax_o = arg_q;
`else
  logic unused_argmax;
  assign unused_argmax = start_ok ^ capture;
  assign argmax_o      = '0;
`endif

endmodule
